// File: rtl/node_stream_injector_if.sv
// Bundle of the node-side request handshake, router stream, credit return
// and status signals for node_stream_injector.
interface node_stream_injector_if #(
  parameter int unsigned net_width  = 4,
  parameter int unsigned data_width = 128,
  parameter int unsigned credit_max = 2
);
  localparam int unsigned stream_width = data_width + net_width;
  localparam int unsigned cw           = $clog2(credit_max + 1);

  logic                    req_valid;
  logic                    req_ready;
  logic [net_width-1:0]    req_addr;
  logic [data_width-1:0]   req_data;
  logic [stream_width-1:0] out_stream;
  logic                    out_valid;
  logic                    credit_ret;
  logic                    loop_valid;
  logic [data_width-1:0]   loop_data;
  logic [cw-1:0]           credits;
  logic                    err_credit;

  modport master (
    output req_valid, req_addr, req_data, credit_ret,
    input  req_ready, out_stream, out_valid, loop_valid, loop_data,
           credits, err_credit
  );

  modport slave (
    input  req_valid, req_addr, req_data, credit_ret,
    output req_ready, out_stream, out_valid, loop_valid, loop_data,
           credits, err_credit
  );
endinterface

// File: rtl/node_stream_injector.sv
// Transmit-side router interface: buffers node requests in a FIFO and
// injects them as {addr, data} stream words under credit flow control.
module node_stream_injector #(
  parameter int unsigned           net_width    = 4,
  parameter int unsigned           data_width   = 128,
  parameter int unsigned           stream_width = data_width + net_width,
  parameter int unsigned           fifo_depth   = 4,
  parameter int unsigned           credit_max   = 2,
  parameter logic [net_width-1:0]  local_addr   = '0
) (
  input logic                  clk,
  input logic                  rst,
  node_stream_injector_if.slave io
);
  localparam int unsigned AW = $clog2(fifo_depth);
  localparam int unsigned CW = $clog2(credit_max + 1);

  typedef logic [stream_width-1:0] word_t;

  word_t                 mem_q [fifo_depth];
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         credits_q, credits_d;
  logic                  err_q, err_d;
  word_t                 out_stream_q, out_stream_d;
  logic                  out_valid_q, out_valid_d;
  logic                  loop_valid_q, loop_valid_d;
  logic [data_width-1:0] loop_data_q, loop_data_d;

  logic full, empty, accept, is_local, enq, send;

  // Full when indices match but the wrap bits differ.
  assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                    (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign accept   = io.req_valid && !full;
  assign is_local = (io.req_addr == local_addr);
  assign enq      = accept && !is_local;
  assign send     = !empty && (credits_q != '0);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    credits_d    = credits_q;
    err_d        = err_q;
    out_valid_d  = send;
    out_stream_d = '0;
    loop_valid_d = accept && is_local;
    loop_data_d  = loop_data_q;

    if (enq)
      wr_ptr_d = wr_ptr_q + 1'b1;
    if (send) begin
      rd_ptr_d     = rd_ptr_q + 1'b1;
      out_stream_d = mem_q[rd_ptr_q[AW-1:0]];
    end
    if (accept && is_local)
      loop_data_d = io.req_data;

    // A return with no slot outstanding saturates and flags the router.
    if (io.credit_ret && !send && (credits_q == CW'(credit_max)))
      err_d = 1'b1;
    else
      credits_d = credits_q - CW'(send) + CW'(io.credit_ret);
  end

  always_ff @(posedge clk) begin
    if (enq)
      mem_q[wr_ptr_q[AW-1:0]] <= {io.req_addr, io.req_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      credits_q    <= CW'(credit_max);
      err_q        <= 1'b0;
      out_stream_q <= '0;
      out_valid_q  <= 1'b0;
      loop_valid_q <= 1'b0;
      loop_data_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      credits_q    <= credits_d;
      err_q        <= err_d;
      out_stream_q <= out_stream_d;
      out_valid_q  <= out_valid_d;
      loop_valid_q <= loop_valid_d;
      loop_data_q  <= loop_data_d;
    end
  end

  assign io.req_ready  = !full;
  assign io.out_stream = out_stream_q;
  assign io.out_valid  = out_valid_q;
  assign io.loop_valid = loop_valid_q;
  assign io.loop_data  = loop_data_q;
  assign io.credits    = credits_q;
  assign io.err_credit = err_q;
endmodule
